// File: rtl/mnemonic_decoder.sv
// Purpose: stream ASCII source bytes, compress letters to 5-bit codes, match whitespace-delimited RV32I mnemonics.
// Latency: delimiter accepted in cycle N -> mnem_valid_out in cycle N+2 (N+1 for a drained error token).
// Backpressure: char_ready_out drops in LOOKUP/EMIT; the EMIT token is held stable until mnem_ready_in.
module mnemonic_decoder #(
   parameter int MAX_LEN = 5
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] char_in,
   input  logic       char_valid_in,
   output logic       char_ready_out,
   output logic       mnem_valid_out,
   input  logic       mnem_ready_in,
   output logic [6:0] opcode_out,
   output logic [2:0] funct3_out,
   output logic [6:0] funct7_out,
   output logic       error_out
);

   localparam int KW = MAX_LEN * 5;
   localparam int SW = MAX_LEN * 8;
   localparam int CW = $clog2(MAX_LEN + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCUM  = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] LOOKUP = 3'd3;
   localparam logic [2:0] EMIT   = 3'd4;

   localparam logic [4:0] COMPRESSED__ = 5'h00;
   localparam logic [4:0] COMPRESSED_A = 5'h01;
   localparam logic [4:0] COMPRESSED_B = 5'h02;
   localparam logic [4:0] COMPRESSED_C = 5'h03;
   localparam logic [4:0] COMPRESSED_D = 5'h04;
   localparam logic [4:0] COMPRESSED_E = 5'h05;
   localparam logic [4:0] COMPRESSED_G = 5'h06;
   localparam logic [4:0] COMPRESSED_H = 5'h07;
   localparam logic [4:0] COMPRESSED_I = 5'h08;
   localparam logic [4:0] COMPRESSED_J = 5'h09;
   localparam logic [4:0] COMPRESSED_L = 5'h0A;
   localparam logic [4:0] COMPRESSED_N = 5'h0B;
   localparam logic [4:0] COMPRESSED_O = 5'h0C;
   localparam logic [4:0] COMPRESSED_P = 5'h0D;
   localparam logic [4:0] COMPRESSED_Q = 5'h0E;
   localparam logic [4:0] COMPRESSED_R = 5'h0F;
   localparam logic [4:0] COMPRESSED_S = 5'h10;
   localparam logic [4:0] COMPRESSED_T = 5'h11;
   localparam logic [4:0] COMPRESSED_U = 5'h12;
   localparam logic [4:0] COMPRESSED_W = 5'h13;
   localparam logic [4:0] COMPRESSED_X = 5'h14;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [6:0] F7_SRA = 7'b0100000;
   localparam logic [6:0] F7_SRL = 7'b0000000;
   localparam logic [6:0] F7_IMM = 7'b1111111;

   // Case-folds letters; anything outside the 20-letter alphabet maps to COMPRESSED__ (invalid).
   function automatic logic [4:0] code_of(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      case (u)
         "A": code_of = COMPRESSED_A;
         "B": code_of = COMPRESSED_B;
         "C": code_of = COMPRESSED_C;
         "D": code_of = COMPRESSED_D;
         "E": code_of = COMPRESSED_E;
         "G": code_of = COMPRESSED_G;
         "H": code_of = COMPRESSED_H;
         "I": code_of = COMPRESSED_I;
         "J": code_of = COMPRESSED_J;
         "L": code_of = COMPRESSED_L;
         "N": code_of = COMPRESSED_N;
         "O": code_of = COMPRESSED_O;
         "P": code_of = COMPRESSED_P;
         "Q": code_of = COMPRESSED_Q;
         "R": code_of = COMPRESSED_R;
         "S": code_of = COMPRESSED_S;
         "T": code_of = COMPRESSED_T;
         "U": code_of = COMPRESSED_U;
         "W": code_of = COMPRESSED_W;
         "X": code_of = COMPRESSED_X;
         default: code_of = COMPRESSED__;
      endcase
   endfunction

   function automatic logic is_delim(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h00);
   endfunction

   // Builds a table key from a right-justified ASCII literal: first letter lands in the top slot.
   function automatic logic [KW-1:0] key_of(input logic [SW-1:0] s);
      logic [KW-1:0] k;
      int n;
      k = '0;
      n = 0;
      for (int i = MAX_LEN - 1; i >= 0; i--) begin
         if (s[i*8 +: 8] != 8'h00) begin
            k[(MAX_LEN-1-n)*5 +: 5] = code_of(s[i*8 +: 8]);
            n++;
         end
      end
      return k;
   endfunction

   logic [2:0]    state;
   logic [KW-1:0] key;
   logic [CW-1:0] count;
   logic [4:0]    code;
   logic          delim;
   logic [KW-1:0] ins;
   logic [17:0]   lut;   // {hit, opcode, funct3, funct7}

   // Classify the incoming byte and position its code at the next free key slot.
   always_comb begin
      code  = code_of(char_in);
      delim = is_delim(char_in);
      ins   = KW'(code) << (KW - 5);
      ins   = ins >> (5 * int'(count));
   end

   // RV32I mnemonic table; a miss leaves hit clear and all fields zero.
   always_comb begin
      lut = '0;
      case (key)
         key_of(SW'("add")):   lut = {1'b1, OP_REG,    3'b000, F7_ADD};
         key_of(SW'("sub")):   lut = {1'b1, OP_REG,    3'b000, F7_SUB};
         key_of(SW'("sll")):   lut = {1'b1, OP_REG,    3'b001, F7_ADD};
         key_of(SW'("slt")):   lut = {1'b1, OP_REG,    3'b010, F7_ADD};
         key_of(SW'("sltu")):  lut = {1'b1, OP_REG,    3'b011, F7_ADD};
         key_of(SW'("xor")):   lut = {1'b1, OP_REG,    3'b100, F7_ADD};
         key_of(SW'("srl")):   lut = {1'b1, OP_REG,    3'b101, F7_ADD};
         key_of(SW'("sra")):   lut = {1'b1, OP_REG,    3'b101, F7_SRA};
         key_of(SW'("or")):    lut = {1'b1, OP_REG,    3'b110, F7_ADD};
         key_of(SW'("and")):   lut = {1'b1, OP_REG,    3'b111, F7_ADD};
         key_of(SW'("addi")):  lut = {1'b1, OP_IMM,    3'b000, F7_IMM};
         key_of(SW'("slti")):  lut = {1'b1, OP_IMM,    3'b010, F7_IMM};
         key_of(SW'("sltiu")): lut = {1'b1, OP_IMM,    3'b011, F7_IMM};
         key_of(SW'("xori")):  lut = {1'b1, OP_IMM,    3'b100, F7_IMM};
         key_of(SW'("ori")):   lut = {1'b1, OP_IMM,    3'b110, F7_IMM};
         key_of(SW'("andi")):  lut = {1'b1, OP_IMM,    3'b111, F7_IMM};
         key_of(SW'("slli")):  lut = {1'b1, OP_IMM,    3'b001, F7_SRL};
         key_of(SW'("srli")):  lut = {1'b1, OP_IMM,    3'b101, F7_SRL};
         key_of(SW'("srai")):  lut = {1'b1, OP_IMM,    3'b101, F7_SRA};
         key_of(SW'("lb")):    lut = {1'b1, OP_LOAD,   3'b000, F7_ADD};
         key_of(SW'("lh")):    lut = {1'b1, OP_LOAD,   3'b001, F7_ADD};
         key_of(SW'("lw")):    lut = {1'b1, OP_LOAD,   3'b010, F7_ADD};
         key_of(SW'("lbu")):   lut = {1'b1, OP_LOAD,   3'b100, F7_ADD};
         key_of(SW'("lhu")):   lut = {1'b1, OP_LOAD,   3'b101, F7_ADD};
         key_of(SW'("sb")):    lut = {1'b1, OP_STORE,  3'b000, F7_ADD};
         key_of(SW'("sh")):    lut = {1'b1, OP_STORE,  3'b001, F7_ADD};
         key_of(SW'("sw")):    lut = {1'b1, OP_STORE,  3'b010, F7_ADD};
         key_of(SW'("beq")):   lut = {1'b1, OP_BRANCH, 3'b000, F7_ADD};
         key_of(SW'("bne")):   lut = {1'b1, OP_BRANCH, 3'b001, F7_ADD};
         key_of(SW'("blt")):   lut = {1'b1, OP_BRANCH, 3'b100, F7_ADD};
         key_of(SW'("bge")):   lut = {1'b1, OP_BRANCH, 3'b101, F7_ADD};
         key_of(SW'("bltu")):  lut = {1'b1, OP_BRANCH, 3'b110, F7_ADD};
         key_of(SW'("bgeu")):  lut = {1'b1, OP_BRANCH, 3'b111, F7_ADD};
         key_of(SW'("jal")):   lut = {1'b1, OP_JAL,    3'b000, F7_ADD};
         key_of(SW'("jalr")):  lut = {1'b1, OP_JALR,   3'b000, F7_ADD};
         key_of(SW'("lui")):   lut = {1'b1, OP_LUI,    3'b000, F7_ADD};
         key_of(SW'("auipc")): lut = {1'b1, OP_AUIPC,  3'b000, F7_ADD};
         default:              lut = '0;
      endcase
   end

   // Token FSM: accumulate, drain bad tokens, look up, then hold the result until taken.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= IDLE;
         key        <= '0;
         count      <= '0;
         opcode_out <= '0;
         funct3_out <= '0;
         funct7_out <= '0;
         error_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (char_valid_in && !delim) begin
                  if (code != COMPRESSED__) begin
                     key   <= key | ins;
                     count <= count + 1'b1;
                     state <= ACCUM;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            ACCUM: begin
               if (char_valid_in) begin
                  if (delim) begin
                     state <= LOOKUP;
                  end else if (code != COMPRESSED__ && count < CW'(MAX_LEN)) begin
                     key   <= key | ins;
                     count <= count + 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (char_valid_in && delim) begin
                  opcode_out <= '0;
                  funct3_out <= '0;
                  funct7_out <= '0;
                  error_out  <= 1'b1;
                  state      <= EMIT;
               end
            end
            LOOKUP: begin
               opcode_out <= lut[16:10];
               funct3_out <= lut[9:7];
               funct7_out <= lut[6:0];
               error_out  <= !lut[17];
               state      <= EMIT;
            end
            EMIT: begin
               if (mnem_ready_in) begin
                  key   <= '0;
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake flags follow the state; both are forced low while reset is asserted.
   always_comb begin
      char_ready_out = !rst_in && (state == IDLE || state == ACCUM || state == DRAIN);
      mnem_valid_out = !rst_in && (state == EMIT);
   end

endmodule

// File: tb/tb_mnemonic_decoder.sv
// Bench for mnemonic_decoder: directed scenarios plus randomized token streams.
// Expected tokens come from a string-level tokenizer and a mnemonic dictionary.
// Downstream ready is driven by a mode-controlled process (off / on / random).
module tb_mnemonic_decoder;
   localparam int MAX_LEN = 5;
   localparam logic [17:0] ERR = {1'b1, 17'b0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       char_ready;
   logic       mnem_valid;
   logic       mnem_ready = 1'b0;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       error;

   int total = 0;
   int bad = 0;
   int rdy_mode = 0;
   int got_base = 0;

   logic [17:0] got_q[$];
   logic [17:0] exp_q[$];
   logic [7:0]  stim_q[$];
   logic [17:0] tbl[string];
   string       names[$];

   mnemonic_decoder #(.MAX_LEN(MAX_LEN)) dut (
      .clk_in(clk), .rst_in(rst), .char_in(char_in), .char_valid_in(char_valid),
      .char_ready_out(char_ready), .mnem_valid_out(mnem_valid), .mnem_ready_in(mnem_ready),
      .opcode_out(opcode), .funct3_out(f3), .funct7_out(f7), .error_out(error)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: mnem_ready = 1'b0;
            1: mnem_ready = 1'b1;
            default: mnem_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && mnem_valid && mnem_ready) got_q.push_back({error, opcode, f3, f7});
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   function automatic void add_m(string n, logic [6:0] op, logic [2:0] fn3, logic [6:0] fn7);
      tbl[n] = {1'b0, op, fn3, fn7};
      names.push_back(n);
   endfunction

   function automatic void init_model();
      add_m("add", 7'b0110011, 3'b000, 7'b0000000);  add_m("sub", 7'b0110011, 3'b000, 7'b0100000);
      add_m("sll", 7'b0110011, 3'b001, 7'b0000000);  add_m("slt", 7'b0110011, 3'b010, 7'b0000000);
      add_m("sltu", 7'b0110011, 3'b011, 7'b0000000); add_m("xor", 7'b0110011, 3'b100, 7'b0000000);
      add_m("srl", 7'b0110011, 3'b101, 7'b0000000);  add_m("sra", 7'b0110011, 3'b101, 7'b0100000);
      add_m("or", 7'b0110011, 3'b110, 7'b0000000);   add_m("and", 7'b0110011, 3'b111, 7'b0000000);
      add_m("addi", 7'b0010011, 3'b000, 7'b1111111); add_m("slti", 7'b0010011, 3'b010, 7'b1111111);
      add_m("sltiu", 7'b0010011, 3'b011, 7'b1111111); add_m("xori", 7'b0010011, 3'b100, 7'b1111111);
      add_m("ori", 7'b0010011, 3'b110, 7'b1111111);  add_m("andi", 7'b0010011, 3'b111, 7'b1111111);
      add_m("slli", 7'b0010011, 3'b001, 7'b0000000); add_m("srli", 7'b0010011, 3'b101, 7'b0000000);
      add_m("srai", 7'b0010011, 3'b101, 7'b0100000);
      add_m("lb", 7'b0000011, 3'b000, 7'b0); add_m("lh", 7'b0000011, 3'b001, 7'b0);
      add_m("lw", 7'b0000011, 3'b010, 7'b0); add_m("lbu", 7'b0000011, 3'b100, 7'b0);
      add_m("lhu", 7'b0000011, 3'b101, 7'b0);
      add_m("sb", 7'b0100011, 3'b000, 7'b0); add_m("sh", 7'b0100011, 3'b001, 7'b0);
      add_m("sw", 7'b0100011, 3'b010, 7'b0);
      add_m("beq", 7'b1100011, 3'b000, 7'b0); add_m("bne", 7'b1100011, 3'b001, 7'b0);
      add_m("blt", 7'b1100011, 3'b100, 7'b0); add_m("bge", 7'b1100011, 3'b101, 7'b0);
      add_m("bltu", 7'b1100011, 3'b110, 7'b0); add_m("bgeu", 7'b1100011, 3'b111, 7'b0);
      add_m("jal", 7'b1101111, 3'b000, 7'b0); add_m("jalr", 7'b1100111, 3'b000, 7'b0);
      add_m("lui", 7'b0110111, 3'b000, 7'b0); add_m("auipc", 7'b0010111, 3'b000, 7'b0);
   endfunction

   function automatic bit is_letter(logic [7:0] c);
      string vl = "abcdeghijlnopqrstuwx";
      for (int i = 0; i < vl.len(); i++) if (vl[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   // Split the byte stream on delimiters and look each lower-cased word up in the dictionary.
   function automatic void model_stim();
      string tok = "";
      bit    badc = 1'b0;
      exp_q.delete();
      foreach (stim_q[i]) begin
         logic [7:0] c;
         c = stim_q[i];
         if (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h00) begin
            if (tok.len() > 0 || badc) begin
               if (badc || tok.len() > MAX_LEN || !tbl.exists(tok)) exp_q.push_back(ERR);
               else exp_q.push_back(tbl[tok]);
            end
            tok = "";
            badc = 1'b0;
         end else begin
            if (c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
            if (is_letter(c)) tok = $sformatf("%s%c", tok, c);
            else badc = 1'b1;
         end
      end
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      int n = 0;
      char_in = b;
      char_valid = 1'b1;
      while (!acc && n < 300) begin
         @(negedge clk);
         acc = char_ready;
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (!acc) begin
         bad++;
         $display("FAIL send_byte timeout char_ready=0 need=1 byte=%h", b);
      end
   endtask

   task automatic send_stim(input int gap_max);
      foreach (stim_q[i]) begin
         send_byte(stim_q[i]);
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
            char_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      char_valid = 1'b0;
   endtask

   task automatic wait_tokens(input int n);
      int c = 0;
      while (got_q.size() - got_base < n && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic run_str(input string s, input int gap_max);
      stim_q.delete();
      for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
      model_stim();
      got_base = got_q.size();
      send_stim(gap_max);
      wait_tokens(exp_q.size());
   endtask

   task automatic test_reset();
      rdy_mode = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total += 6;
      if (char_ready !== 1'b0) begin bad++; $display("FAIL rst_char_ready got=%b need=0", char_ready); end
      if (mnem_valid !== 1'b0) begin bad++; $display("FAIL rst_mnem_valid got=%b need=0", mnem_valid); end
      if (opcode !== 7'b0) begin bad++; $display("FAIL rst_opcode got=%b need=0", opcode); end
      if (f3 !== 3'b0) begin bad++; $display("FAIL rst_funct3 got=%b need=0", f3); end
      if (f7 !== 7'b0) begin bad++; $display("FAIL rst_funct7 got=%b need=0", f7); end
      if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b need=0", error); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (char_ready !== 1'b1) begin bad++; $display("FAIL post_rst_char_ready got=%b need=1", char_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_latency();
      rdy_mode = 1;
      send_byte("a"); send_byte("d"); send_byte("d"); send_byte(" ");
      char_valid = 1'b0;
      @(negedge clk);
      total++;
      if (mnem_valid !== 1'b0) begin bad++; $display("FAIL add_valid_n1 got=%b need=0", mnem_valid); end
      @(posedge clk);
      #1;
      @(negedge clk);
      total += 2;
      if (mnem_valid !== 1'b1) begin bad++; $display("FAIL add_valid_n2 got=%b need=1", mnem_valid); end
      if ({error, opcode, f3, f7} !== {1'b0, 7'b0110011, 3'b000, 7'b0000000}) begin
         bad++; $display("FAIL add_fields got=%b/%b/%b/%b need=0/0110011/000/0000000", error, opcode, f3, f7);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (mnem_valid !== 1'b0) begin bad++; $display("FAIL add_valid_n3 got=%b need=0", mnem_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_case_and_delims();
      rdy_mode = 1;
      run_str("SRAI\nandi\t  auipc  bgeu ", 1);
      total++;
      if (got_q.size() - got_base != 4) begin
         bad++; $display("FAIL case_delim_count got=%0d need=4", got_q.size() - got_base);
      end else begin
         total += 4;
         if (got_q[got_base] !== {1'b0, 7'b0010011, 3'b101, 7'b0100000}) begin bad++; $display("FAIL srai got=%h need=%h", got_q[got_base], {1'b0, 7'b0010011, 3'b101, 7'b0100000}); end
         if (got_q[got_base+1] !== {1'b0, 7'b0010011, 3'b111, 7'b1111111}) begin bad++; $display("FAIL andi got=%h need=%h", got_q[got_base+1], {1'b0, 7'b0010011, 3'b111, 7'b1111111}); end
         if (got_q[got_base+2] !== {1'b0, 7'b0010111, 3'b000, 7'b0000000}) begin bad++; $display("FAIL auipc got=%h need=%h", got_q[got_base+2], {1'b0, 7'b0010111, 3'b000, 7'b0000000}); end
         if (got_q[got_base+3] !== {1'b0, 7'b1100011, 3'b111, 7'b0000000}) begin bad++; $display("FAIL bgeu got=%h need=%h", got_q[got_base+3], {1'b0, 7'b1100011, 3'b111, 7'b0000000}); end
      end
   endtask

   task automatic test_errors();
      rdy_mode = 1;
      run_str("mul sltiuu ad bltuu lw ", 0);
      total++;
      if (got_q.size() - got_base != 5) begin
         bad++; $display("FAIL err_count got=%0d need=5", got_q.size() - got_base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q[got_base+i] !== ERR) begin bad++; $display("FAIL err_tok%0d got=%h need=%h", i, got_q[got_base+i], ERR); end
         end
         total++;
         if (got_q[got_base+4] !== {1'b0, 7'b0000011, 3'b010, 7'b0}) begin
            bad++; $display("FAIL lw_after_err got=%h need=%h", got_q[got_base+4], {1'b0, 7'b0000011, 3'b010, 7'b0});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [17:0] snap;
      int n = 0;
      rdy_mode = 0;
      got_base = got_q.size();
      send_byte("s"); send_byte("w"); send_byte(" ");
      char_in = "l";
      char_valid = 1'b1;
      @(negedge clk);
      while (!mnem_valid && n < 20) begin
         @(posedge clk); #1; @(negedge clk); n++;
      end
      snap = {error, opcode, f3, f7};
      total++;
      if (snap !== {1'b0, 7'b0100011, 3'b010, 7'b0}) begin bad++; $display("FAIL bp_sw got=%h need=%h", snap, {1'b0, 7'b0100011, 3'b010, 7'b0}); end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
         total += 3;
         if (mnem_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b need=1", i, mnem_valid); end
         if ({error, opcode, f3, f7} !== snap) begin bad++; $display("FAIL bp_stable%0d got=%h need=%h", i, {error, opcode, f3, f7}, snap); end
         if (char_ready !== 1'b0) begin bad++; $display("FAIL bp_char_ready%0d got=%b need=0", i, char_ready); end
      end
      @(posedge clk);
      #1;
      rdy_mode = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      total += 2;
      if (char_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b need=1", char_ready); end
      if (mnem_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b need=0", mnem_valid); end
      @(posedge clk);
      #1;
      send_byte("w"); send_byte(" ");
      char_valid = 1'b0;
      wait_tokens(2);
      total++;
      if (got_q.size() - got_base != 2) begin
         bad++; $display("FAIL bp_count got=%0d need=2", got_q.size() - got_base);
      end else begin
         total++;
         if (got_q[got_base+1] !== {1'b0, 7'b0000011, 3'b010, 7'b0}) begin bad++; $display("FAIL bp_lw got=%h need=%h", got_q[got_base+1], {1'b0, 7'b0000011, 3'b010, 7'b0}); end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      rdy_mode = 1;
      base = got_q.size();
      send_byte("b"); send_byte("l");
      char_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      total += 2;
      if (char_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b need=0", char_ready); end
      if (mnem_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b need=0", mnem_valid); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      total += 2;
      if (got_q.size() != base) begin bad++; $display("FAIL midrst_emit got=%0d need=0", got_q.size() - base); end
      if (char_ready !== 1'b1) begin bad++; $display("FAIL midrst_after_ready got=%b need=1", char_ready); end
      @(posedge clk);
      #1;
      run_str("beq ", 0);
      total++;
      if (got_q.size() - got_base != 1 || got_q[got_base] !== {1'b0, 7'b1100011, 3'b000, 7'b0}) begin
         bad++; $display("FAIL midrst_beq got_n=%0d need_n=1 need=%h", got_q.size() - got_base, {1'b0, 7'b1100011, 3'b000, 7'b0});
      end
   endtask

   task automatic gen_random(input int ntok);
      logic [7:0] dl[5] = '{8'h20, 8'h09, 8'h0A, 8'h0D, 8'h00};
      string vl = "abcdeghijlnopqrstuwx";
      string bs = "fkmvyz1_.";
      stim_q.delete();
      for (int k = 0; k < ntok; k++) begin
         string n, t;
         int kind, pos;
         logic [7:0] c;
         n = names[$urandom_range(0, names.size() - 1)];
         kind = $urandom_range(0, 9);
         t = "";
         case (kind)
            6: repeat ($urandom_range(1, 7)) t = $sformatf("%s%c", t, vl[$urandom_range(0, 19)]);
            7: t = n.substr(0, n.len() - 2);
            8: begin
               pos = $urandom_range(0, n.len() - 1);
               for (int i = 0; i < n.len(); i++) t = $sformatf("%s%c", t, (i == pos) ? bs[$urandom_range(0, 8)] : n[i]);
            end
            9: t = $sformatf("%s%c", n, vl[$urandom_range(0, 19)]);
            default: t = n;
         endcase
         for (int i = 0; i < t.len(); i++) begin
            c = t[i];
            if ($urandom_range(0, 3) == 0 && c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
            stim_q.push_back(c);
         end
         repeat ($urandom_range(1, 3)) stim_q.push_back(dl[$urandom_range(0, 4)]);
      end
   endtask

   task automatic test_random();
      rdy_mode = 2;
      for (int r = 0; r < 6; r++) begin
         gen_random(14);
         model_stim();
         got_base = got_q.size();
         send_stim((r % 2 == 0) ? 0 : 2);
         wait_tokens(exp_q.size());
         total++;
         if (got_q.size() - got_base != exp_q.size()) begin
            bad++; $display("FAIL rand%0d_count got=%0d need=%0d", r, got_q.size() - got_base, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
            total++;
            if (got_q[got_base+i] !== exp_q[i]) begin
               bad++; $display("FAIL rand%0d_tok%0d got=%h need=%h", r, i, got_q[got_base+i], exp_q[i]);
            end
         end
      end
      rdy_mode = 1;
   endtask

   initial begin
      init_model();
      test_reset();
      test_add_latency();
      test_case_and_delims();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
